// File: rtl/ub_pkg.sv
// Unified-buffer shared definitions: geometry, tile shape and the reader state encoding.
package ub_pkg;

  localparam int UB_DEPTH     = 64;
  localparam int UB_ADDR_W    = 6;
  localparam int UB_DATA_W    = 32;
  localparam int TILE_WORDS   = 4;
  localparam int STREAM_BEATS = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    STREAM,
    DONE
  } rd_state_e;

endpackage

// File: rtl/activation_skew.sv
// Holds the 2x2 activation tile and drives the two systolic lanes, lane1 one beat behind lane0.
module activation_skew
  import ub_pkg::*;
#(
  parameter int DATA_WIDTH = UB_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_en,
  input  logic [1:0]            cap_idx,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  stream_en,
  input  logic [1:0]            stream_beat,
  output logic [DATA_WIDTH-1:0] act_row0,
  output logic [DATA_WIDTH-1:0] act_row1,
  output logic                  act_valid
);

  logic [DATA_WIDTH-1:0] tile_q [TILE_WORDS];
  logic [DATA_WIDTH-1:0] row0_n;
  logic [DATA_WIDTH-1:0] row1_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TILE_WORDS; i++) tile_q[i] <= '0;
    end else if (cap_en) begin
      tile_q[cap_idx] <= cap_data;
    end
  end

  // stream_en/stream_beat describe the coming cycle, so the lanes register straight from them.
  always_comb begin
    row0_n = '0;
    row1_n = '0;
    if (stream_en) begin
      case (stream_beat)
        2'd0: row0_n = tile_q[0];
        2'd1: begin
          row0_n = tile_q[1];
          row1_n = tile_q[2];
        end
        2'd2: row1_n = tile_q[3];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_row0  <= '0;
      act_row1  <= '0;
      act_valid <= 1'b0;
    end else begin
      act_row0  <= row0_n;
      act_row1  <= row1_n;
      act_valid <= stream_en;
    end
  end

endmodule

// File: rtl/ub_activation_reader.sv
// Fetches a 2x2 activation tile from the unified buffer and streams it skewed into the systolic lanes.
module ub_activation_reader
  import ub_pkg::*;
#(
  parameter int DATA_WIDTH = UB_DATA_W,
  parameter int ADDR_WIDTH = UB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] act_row0,
  output logic [DATA_WIDTH-1:0] act_row1,
  output logic                  act_valid,
  output logic                  busy,
  output logic                  done
);

  rd_state_e             state_q, state_n;
  logic [1:0]            beat_q, beat_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic                  rd_pend_q;
  logic [1:0]            cap_idx_q;

  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    base_n  = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          beat_n  = '0;
          base_n  = base_addr;
        end
      end
      FETCH: begin
        if (beat_q == 2'(TILE_WORDS - 1)) begin
          state_n = CAPTURE;
          beat_n  = '0;
        end else begin
          beat_n = beat_q + 2'd1;
        end
      end
      CAPTURE: begin
        state_n = STREAM;
        beat_n  = '0;
      end
      STREAM: begin
        if (beat_q == 2'(STREAM_BEATS - 1)) begin
          state_n = DONE;
          beat_n  = '0;
        end else begin
          beat_n = beat_q + 2'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_pend_q <= 1'b0;
      cap_idx_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      beat_q    <= beat_n;
      base_q    <= base_n;
      rd_en     <= (state_n == FETCH);
      rd_addr   <= (state_n == FETCH) ? base_n + ADDR_WIDTH'(beat_n) : '0;
      rd_pend_q <= rd_en;
      cap_idx_q <= beat_q;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

  activation_skew #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew (
    .clk         (clk),
    .reset       (reset),
    .cap_en      (rd_pend_q),
    .cap_idx     (cap_idx_q),
    .cap_data    (rd_data),
    .stream_en   (state_n == STREAM),
    .stream_beat (beat_n),
    .act_row0    (act_row0),
    .act_row1    (act_row1),
    .act_valid   (act_valid)
  );

endmodule

// File: tb/tb_ub_activation_reader.sv
// Directed per-cycle vector bench for ub_activation_reader with a synchronous-read buffer model.
module tb_ub_activation_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] act_row0;
  logic [31:0] act_row1;
  logic        act_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [64];

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  ub_activation_reader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .act_row0  (act_row0),
    .act_row1  (act_row1),
    .act_valid (act_valid),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        start;
    logic [5:0]  base;
    logic        chk;
    logic        en;
    logic [5:0]  addr;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        val;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t q[$];

  function automatic vec_t row(logic rst, logic st, logic [5:0] b, logic en, logic [5:0] addr,
                               logic [31:0] r0, logic [31:0] r1, logic val, logic bsy, logic dn);
    vec_t v;
    v.rst = rst; v.start = st; v.base = b; v.chk = 1'b1;
    v.en = en; v.addr = addr; v.r0 = r0; v.r1 = r1; v.val = val; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  function automatic vec_t idle(logic rst, logic st, logic [5:0] b);
    return row(rst, st, b, 1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Rows T..T+10 of one undisturbed tile; addresses and words are given explicitly.
  task automatic push_tile(input logic [5:0] b, input logic [5:0] a0, input logic [5:0] a1,
                           input logic [5:0] a2, input logic [5:0] a3, input logic [31:0] w00,
                           input logic [31:0] w01, input logic [31:0] w10, input logic [31:0] w11);
    q.push_back(idle(1'b0, 1'b1, b));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b1, a0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b1, a1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b1, a2, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b1, a3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, w00, 32'd0, 1'b1, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, w01, w10, 1'b1, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, 32'd0, w11, 1'b1, 1'b1, 1'b0));
    q.push_back(row(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1));
    q.push_back(idle(1'b0, 1'b0, 6'h00));
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Each row: outputs seen during the cycle, inputs sampled at its closing edge.
  task automatic apply(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (q[i].chk) begin
        chk({tag, ".rd_en"},     i, 32'(rd_en),     32'(q[i].en));
        chk({tag, ".rd_addr"},   i, 32'(rd_addr),   32'(q[i].addr));
        chk({tag, ".act_row0"},  i, act_row0,       q[i].r0);
        chk({tag, ".act_row1"},  i, act_row1,       q[i].r1);
        chk({tag, ".act_valid"}, i, 32'(act_valid), 32'(q[i].val));
        chk({tag, ".busy"},      i, 32'(busy),      32'(q[i].bsy));
        chk({tag, ".done"},      i, 32'(done),      32'(q[i].dn));
      end
      reset     = q[i].rst;
      start     = q[i].start;
      base_addr = q[i].base;
    end
    q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    base_addr = 6'h2A;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i);
    mem[6'h1E] = 32'd11; mem[6'h1F] = 32'd12; mem[6'h20] = 32'd21; mem[6'h21] = 32'd22;
    mem[6'h3E] = 32'd5;  mem[6'h3F] = 32'd6;  mem[6'h00] = 32'd7;  mem[6'h01] = 32'd8;
    mem[6'h02] = 32'h33; mem[6'h03] = 32'h44;

    // Reset held two cycles with start high; first cycle is pre-reset and unchecked.
    q.push_back(idle(1'b1, 1'b1, 6'h2A));
    q[0].chk = 1'b0;
    q.push_back(idle(1'b1, 1'b1, 6'h2A));
    q.push_back(idle(1'b0, 1'b0, 6'h00));
    q.push_back(idle(1'b0, 1'b0, 6'h00));
    apply("reset");

    push_tile(6'h1E, 6'h1E, 6'h1F, 6'h20, 6'h21, 32'd11, 32'd12, 32'd21, 32'd22);
    apply("basic");

    push_tile(6'h3E, 6'h3E, 6'h3F, 6'h00, 6'h01, 32'd5, 32'd6, 32'd7, 32'd8);
    apply("wrap");

    // Second start at T+3 is dropped; the one at T+10 (IDLE) is taken.
    push_tile(6'h1E, 6'h1E, 6'h1F, 6'h20, 6'h21, 32'd11, 32'd12, 32'd21, 32'd22);
    q[3].start = 1'b1; q[3].base = 6'h00;
    q[10].start = 1'b1; q[10].base = 6'h00;
    push_tile(6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 32'd7, 32'd8, 32'h33, 32'h44);
    q.delete(11);
    apply("busy_rej");

    // Reset at T+7 kills the tile; a start at T+9 then runs clean.
    push_tile(6'h1E, 6'h1E, 6'h1F, 6'h20, 6'h21, 32'd11, 32'd12, 32'd21, 32'd22);
    while (q.size() > 8) q.pop_back();
    q[7].rst = 1'b1;
    q.push_back(idle(1'b0, 1'b0, 6'h00));
    q.push_back(idle(1'b0, 1'b1, 6'h1E));
    push_tile(6'h1E, 6'h1E, 6'h1F, 6'h20, 6'h21, 32'd11, 32'd12, 32'd21, 32'd22);
    q.delete(10);
    apply("mid_reset");

    q.push_back(idle(1'b1, 1'b1, 6'h10));
    q.push_back(idle(1'b0, 1'b0, 6'h00));
    q.push_back(idle(1'b0, 1'b0, 6'h00));
    apply("rst_vs_start");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ub_activation_reader.md
Name: ub_activation_reader

Overview:
Read-side companion to the unified buffer. On a start command it fetches a 2x2 activation tile (4 consecutive words) through the buffer's synchronous read port. It then streams the tile into the systolic array input lanes with diagonal skew: lane1 runs one cycle behind lane0. It handshakes with the top-level controller via start/busy/done.

Parameters:
DATA_WIDTH, 32, width of one unified-buffer word and of each activation lane
ADDR_WIDTH, 6, unified-buffer address width (64 entries); address arithmetic wraps modulo 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  tile base address; captured on accepted start
rd_en  output  1  read request to unified buffer
rd_addr  output  ADDR_WIDTH  read address
rd_data  input  DATA_WIDTH  read data; valid exactly 1 cycle after rd_en
act_row0  output  DATA_WIDTH  systolic lane 0 activation
act_row1  output  DATA_WIDTH  systolic lane 1 activation
act_valid  output  1  lanes carry a tile beat
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset and clock: clk is the only clock. reset is synchronous and active-high, sampled on the rising edge of clk, and has priority over everything, including a start in the same cycle.
- Reset values: all outputs 0, state IDLE, captured base and the four tile registers 0.
- Tile layout: word base+0 is a00, base+1 is a01, base+2 is a10, base+3 is a11.
- Each base+k is computed in ADDR_WIDTH bits, so it wraps (0x3F+1 = 0x00).
- All outputs are registered. Timings below are cycles relative to start being sampled high in IDLE at cycle T.
- FSM states: IDLE, FETCH (4 cycles, beat counter 0..3), CAPTURE (1), STREAM (3, beat counter 0..2), DONE (1), then back to IDLE.
- IDLE: rd_en=0, rd_addr=0, act_*=0, busy=0. On start, latch base_addr and go to FETCH.
- FETCH, T+1..T+4: rd_en=1, rd_addr = base+beat.
- Capture: rd_data is latched into the tile registers at T+2..T+5 (a00, a01, a10, a11). CAPTURE at T+5 latches a11. rd_en=0 from T+5.
- STREAM beats, act_valid=1:
  - T+6: row0=a00, row1=0
  - T+7: row0=a01, row1=a10
  - T+8: row0=0, row1=a11
- Outside STREAM, act_valid=0 and act_row0/act_row1=0.
- DONE at T+9: done=1, busy=1. T+10: IDLE.
- Earliest next accepted start: T+10.
- start outside IDLE is ignored: no queuing, no base re-capture.
- base_addr is ignored except in the accept cycle.
- Reset mid-operation, in any state: next cycle is IDLE with all reset values. No done pulse; the partial tile is discarded.
- rd_data is don't-care in cycles without a pending read.
- The block never writes the buffer. Read/write collision avoidance is the controller's responsibility.

Decomposition:
- Shared package ub_pkg holds:
  - UB_DEPTH=64, UB_ADDR_W=6, UB_DATA_W=32
  - the reader state enum (IDLE, FETCH, CAPTURE, STREAM, DONE)
  - TILE_WORDS=4, STREAM_BEATS=3
- One natural sub-module, activation_skew. It holds the four tile registers and produces act_row0/act_row1/act_valid from the stream beat index.
- The FSM, counters and read-port logic stay in ub_activation_reader.

Test Plan:
1. Reset: hold reset 2 cycles with start=1 -> rd_en, act_valid, busy, done, act_row0/1 all 0; state IDLE.
2. Basic tile: memory model mem[0x1E..0x21] = 11, 12, 21, 22; start with base=0x1E at T.
   - rd_addr 0x1E, 0x1F, 0x20, 0x21 with rd_en=1 at T+1..T+4.
   - (row0, row1) = (11,0), (12,21), (0,22) at T+6..T+8.
   - done=1 at T+9 only; busy=1 over T+1..T+9.
3. Wrap-around: mem[0x3E]=5, mem[0x3F]=6, mem[0x00]=7, mem[0x01]=8; base=0x3E.
   - rd_addr sequence 0x3E, 0x3F, 0x00, 0x01.
   - Stream (5,0), (6,7), (0,8).
4. Busy rejection: start base=0x1E at T, start again base=0x00 at T+3 -> only one fetch, from 0x1E, and one done at T+9. Start base=0x00 at T+10 -> accepted, fetch 0x00..0x03.
5. Reset mid-stream: assert reset at T+7 -> at T+8 all outputs 0, no done at T+9. A new start at T+9 runs a full, correct tile.
6. Same-cycle start and reset in IDLE -> reset wins. No rd_en on the following cycle; busy stays 0.
